// File: rtl/px_skip_shadow_csr_if.sv
// AXI4-Lite bus bundle (32-bit address/data) used by the pixel-skipper CSR block.
interface axi4_lite_if;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/px_skip_shadow_csr.sv
// AXI4-Lite CSR block for the pixel skipper: staging registers on the bus side,
// optional frame-synchronous shadow copy on the output side (PX_SKIP_CSR_SHADOW_EN).
module px_skip_shadow_csr #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned CNT_W     = 8,
    parameter logic [31:0] ID_VALUE  = 32'h5053_0002
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    axi4_lite_if.slave       csr_i,
    input  logic             sof_i,
    output logic [CNT_W-1:0] px_to_skip_o,
    output logic [CNT_W-1:0] px_skip_interval_o,
    output logic [CNT_W-1:0] add_px_skip_interval_o,
    output logic [CNT_W-1:0] ln_to_skip_o,
    output logic [CNT_W-1:0] ln_skip_interval_o,
    output logic [CNT_W-1:0] add_ln_skip_interval_o,
    output logic             skip_en_o
);
    typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} wr_state_t;

    wr_state_t        wr_state, wr_state_next;
    logic             aw_hs, w_hs, do_write;
    logic [31:0]      addr_q, data_q;
    logic [3:0]       strb_q;
    logic [1:0]       bresp_q;
    logic [31:0]      wr_addr, wr_data, wr_off, strb_bits;
    logic [3:0]       wr_strb;
    logic [2:0]       wr_idx;
    logic             wr_in_win, stage_write;
    logic [CNT_W-1:0] wmask, wfield;

    logic [CNT_W-1:0] stage [6];
    logic             en_stage;
    logic             pending_rd;

    logic [31:0]      rd_off, rd_word;
    logic [2:0]       rd_idx;
    logic             rd_in_win;
    logic             rvalid_q;
    logic [31:0]      rdata_q;
    logic [1:0]       rresp_q;

    // Write channel: AW and W may arrive in either order; the write lands on the edge
    // that completes the pair, using whichever half is still live on the bus.
    always_comb begin
        wr_state_next = wr_state;
        csr_i.awready = 1'b0;
        csr_i.wready  = 1'b0;
        csr_i.bvalid  = 1'b0;
        do_write      = 1'b0;
        case (wr_state)
            W_IDLE: begin
                csr_i.awready = 1'b1;
                csr_i.wready  = 1'b1;
                if (csr_i.awvalid && csr_i.wvalid) begin
                    do_write      = 1'b1;
                    wr_state_next = W_RESP;
                end else if (csr_i.awvalid) begin
                    wr_state_next = W_HAVE_ADDR;
                end else if (csr_i.wvalid) begin
                    wr_state_next = W_HAVE_DATA;
                end
            end
            W_HAVE_ADDR: begin
                csr_i.wready = 1'b1;
                if (csr_i.wvalid) begin
                    do_write      = 1'b1;
                    wr_state_next = W_RESP;
                end
            end
            W_HAVE_DATA: begin
                csr_i.awready = 1'b1;
                if (csr_i.awvalid) begin
                    do_write      = 1'b1;
                    wr_state_next = W_RESP;
                end
            end
            W_RESP: begin
                csr_i.bvalid = 1'b1;
                if (csr_i.bready) wr_state_next = W_IDLE;
            end
            default: wr_state_next = W_IDLE;
        endcase
    end

    assign aw_hs       = csr_i.awvalid && csr_i.awready;
    assign w_hs        = csr_i.wvalid && csr_i.wready;
    assign csr_i.bresp = bresp_q;

    assign wr_addr   = (wr_state == W_HAVE_ADDR) ? addr_q : csr_i.awaddr;
    assign wr_data   = (wr_state == W_HAVE_DATA) ? data_q : csr_i.wdata;
    assign wr_strb   = (wr_state == W_HAVE_DATA) ? strb_q : csr_i.wstrb;
    assign wr_off    = wr_addr - BASE_ADDR;
    assign wr_in_win = wr_off < 32'd32;
    assign wr_idx    = wr_off[4:2];
    assign strb_bits = {{8{wr_strb[3]}}, {8{wr_strb[2]}}, {8{wr_strb[1]}}, {8{wr_strb[0]}}};
    assign wmask     = strb_bits[CNT_W-1:0];
    assign wfield    = wr_data[CNT_W-1:0];

    assign stage_write = do_write && wr_in_win &&
                         ((wr_idx < 3'd6) || ((wr_idx == 3'd6) && wr_strb[0]));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) wr_state <= W_IDLE;
        else          wr_state <= wr_state_next;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            addr_q  <= '0;
            data_q  <= '0;
            strb_q  <= '0;
            bresp_q <= '0;
        end else begin
            if (aw_hs) addr_q <= csr_i.awaddr;
            if (w_hs) begin
                data_q <= csr_i.wdata;
                strb_q <= csr_i.wstrb;
            end
            if (do_write) bresp_q <= wr_in_win ? 2'b00 : 2'b10;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stage    <= '{default: '0};
            en_stage <= 1'b0;
        end else if (stage_write) begin
            if (wr_idx < 3'd6) stage[wr_idx] <= (stage[wr_idx] & ~wmask) | (wfield & wmask);
            else               en_stage      <= wr_data[0];
        end
    end

`ifdef PX_SKIP_CSR_SHADOW_EN
    logic [CNT_W-1:0] active [6];
    logic             en_active, pending, apply_q, commit;

    // A write coinciding with sof commits the pre-write staging and leaves PENDING set.
    assign commit = (sof_i && pending) || apply_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            active    <= '{default: '0};
            en_active <= 1'b0;
            pending   <= 1'b0;
            apply_q   <= 1'b0;
        end else begin
            apply_q <= stage_write && (wr_idx == 3'd6) && wr_data[1];
            if (commit) begin
                active    <= stage;
                en_active <= en_stage;
            end
            if (stage_write) pending <= 1'b1;
            else if (commit) pending <= 1'b0;
        end
    end

    assign px_to_skip_o           = active[0];
    assign px_skip_interval_o     = active[1];
    assign add_px_skip_interval_o = active[2];
    assign ln_to_skip_o           = active[3];
    assign ln_skip_interval_o     = active[4];
    assign add_ln_skip_interval_o = active[5];
    assign skip_en_o              = en_active;
    assign pending_rd             = pending;

    logic unused_bits;
    assign unused_bits = ^{wr_data, strb_bits};
`else
    assign px_to_skip_o           = stage[0];
    assign px_skip_interval_o     = stage[1];
    assign add_px_skip_interval_o = stage[2];
    assign ln_to_skip_o           = stage[3];
    assign ln_skip_interval_o     = stage[4];
    assign add_ln_skip_interval_o = stage[5];
    assign skip_en_o              = en_stage;
    assign pending_rd             = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{wr_data, strb_bits, sof_i};
`endif

    assign rd_off        = csr_i.araddr - BASE_ADDR;
    assign rd_in_win     = rd_off < 32'd32;
    assign rd_idx        = rd_off[4:2];
    assign csr_i.arready = !rvalid_q;
    assign csr_i.rvalid  = rvalid_q;
    assign csr_i.rdata   = rdata_q;
    assign csr_i.rresp   = rresp_q;

    always_comb begin
        rd_word = '0;
        if (rd_in_win) begin
            if (rd_idx < 3'd6)       rd_word[CNT_W-1:0] = stage[rd_idx];
            else if (rd_idx == 3'd6) rd_word[2:0]       = {pending_rd, 1'b0, en_stage};
            else                     rd_word            = ID_VALUE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= '0;
        end else if (csr_i.arvalid && !rvalid_q) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_word;
            rresp_q  <= rd_in_win ? 2'b00 : 2'b10;
        end else if (rvalid_q && csr_i.rready) begin
            rvalid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_px_skip_shadow_csr.sv
// Directed self-checking bench for px_skip_shadow_csr; expectations follow PX_SKIP_CSR_SHADOW_EN.
module tb_px_skip_shadow_csr;
    localparam int unsigned CNT_W = 8;
    localparam logic [31:0] ID    = 32'h5053_0002;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sof = 1'b0;
    logic [CNT_W-1:0] px_skip, px_int, px_add, ln_skip, ln_int, ln_add;
    logic skip_en;
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    axi4_lite_if bus ();

    px_skip_shadow_csr #(
        .BASE_ADDR (32'h0000_0000),
        .CNT_W     (CNT_W),
        .ID_VALUE  (ID)
    ) dut (
        .clk_i                  (clk),
        .rst_n_i                (rst_n),
        .csr_i                  (bus),
        .sof_i                  (sof),
        .px_to_skip_o           (px_skip),
        .px_skip_interval_o     (px_int),
        .add_px_skip_interval_o (px_add),
        .ln_to_skip_o           (ln_skip),
        .ln_skip_interval_o     (ln_int),
        .add_ln_skip_interval_o (ln_add),
        .skip_en_o              (skip_en)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int cyc;
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        bus.rready  = 1'b0;
        cyc = 0;
        @(negedge clk);
        while (!bus.arready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (!bus.arready) check("ar_timeout", 32'(bus.arready), 32'd1);
        cycle();
        bus.arvalid = 1'b0;
        check("rvalid_rise", 32'(bus.rvalid), 32'd1);
        data = bus.rdata;
        resp = bus.rresp;
        bus.rready = 1'b1;
        cycle();
        bus.rready = 1'b0;
    endtask

    // lead: 1 = W one cycle ahead of AW, -1 = AW ahead of W, 0 = same cycle.
    task automatic write_start(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                               input int lead, input bit sof_at_end);
        bit aw_done, w_done;
        int cyc;
        aw_done     = 1'b0;
        w_done      = 1'b0;
        bus.awaddr  = addr;
        bus.wdata   = data;
        bus.wstrb   = strb;
        bus.bready  = 1'b0;
        bus.awvalid = (lead <= 0);
        bus.wvalid  = (lead >= 0);
        cyc = 0;
        while (!(aw_done && w_done) && cyc < 20) begin
            @(negedge clk);
            if (bus.awvalid && bus.awready) aw_done = 1'b1;
            if (bus.wvalid && bus.wready)   w_done  = 1'b1;
            if (aw_done && w_done && sof_at_end) sof = 1'b1;
            cycle();
            sof = 1'b0;
            if (aw_done) bus.awvalid = 1'b0;
            else         bus.awvalid = 1'b1;
            if (w_done)  bus.wvalid  = 1'b0;
            else         bus.wvalid  = 1'b1;
            cyc++;
        end
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        if (!(aw_done && w_done)) check("aw_w_timeout", 32'({aw_done, w_done}), 32'd3);
        check("bvalid_rise", 32'(bus.bvalid), 32'd1);
    endtask

    task automatic write_finish(input int hold, output logic [1:0] resp);
        resp = bus.bresp;
        for (int i = 0; i < hold; i++) begin
            check("bvalid_hold", 32'(bus.bvalid), 32'd1);
            check("bresp_hold", 32'(bus.bresp), 32'(resp));
            check("aw_w_ready_low", 32'({bus.awready, bus.wready}), 32'd0);
            cycle();
        end
        bus.bready = 1'b1;
        cycle();
        bus.bready = 1'b0;
        check("ready_after_b", 32'({bus.awready, bus.wready, bus.bvalid}), 32'b110);
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int lead, output logic [1:0] resp);
        write_start(addr, data, strb, lead, 1'b0);
        write_finish(0, resp);
    endtask

    task automatic pulse_sof();
        sof = 1'b1;
        cycle();
        sof = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [1:0]  resp;
        logic [31:0] exp_words [8];
        bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
        bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        exp_words = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, ID};

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        cycle();

        // Reset state
        check("rst_ready", 32'({bus.awready, bus.wready, bus.arready}), 32'b111);
        check("rst_valid", 32'({bus.bvalid, bus.rvalid}), 32'b00);
        check("rst_rdata", bus.rdata, 32'd0);
        check("rst_outputs", 32'({px_skip, px_int, px_add, ln_skip} | {ln_int, ln_add, 15'd0, skip_en}), 32'd0);
        for (int i = 0; i < 8; i++) begin
            axi_read(32'(i * 4), rd, resp);
            check($sformatf("rst_word%0d", i), rd, exp_words[i]);
            check($sformatf("rst_rresp%0d", i), 32'(resp), 32'd0);
        end

        // PX_SKIP write, W ahead of AW; upper bits beyond CNT_W dropped
        axi_write(32'h0, 32'h0000_01A5, 4'hF, 1, resp);
        check("px_skip_bresp", 32'(resp), 32'd0);
        axi_read(32'h0, rd, resp);
        check("px_skip_readback", rd, 32'h0000_00A5);
`ifdef PX_SKIP_CSR_SHADOW_EN
        check("px_skip_not_yet", 32'(px_skip), 32'h00);
        axi_read(32'h18, rd, resp);
        check("ctrl_pending", rd, 32'h4);
`else
        check("px_skip_direct", 32'(px_skip), 32'hA5);
        axi_read(32'h18, rd, resp);
        check("ctrl_no_pending", rd, 32'h0);
`endif
        pulse_sof();
        check("px_skip_after_sof", 32'(px_skip), 32'hA5);
        axi_read(32'h18, rd, resp);
        check("ctrl_after_sof", rd, 32'h0);

        // LN_INTERVAL then CTRL EN|APPLY, AW ahead of W
        axi_write(32'h10, 32'h33, 4'hF, 0, resp);
        axi_write(32'h18, 32'h3, 4'hF, -1, resp);
        check("apply_ln_int", 32'(ln_int), 32'h33);
        check("apply_en", 32'(skip_en), 32'd1);
        axi_read(32'h18, rd, resp);
        check("ctrl_after_apply", rd, 32'h1);

        // Out-of-window accesses
        axi_write(32'h40, 32'h77, 4'hF, 0, resp);
        check("oow_bresp", 32'(resp), 32'd2);
        axi_read(32'h40, rd, resp);
        check("oow_rdata", rd, 32'd0);
        check("oow_rresp", 32'(resp), 32'd2);
        axi_read(32'h0, rd, resp);
        check("oow_no_change", rd, 32'hA5);
        axi_read(32'h18, rd, resp);
        check("oow_no_pending", rd, 32'h1);

        // Byte strobes: only byte 0 lies within CNT_W
        axi_write(32'h4, 32'hFFFF_FF5A, 4'b1110, 0, resp);
        axi_read(32'h4, rd, resp);
        check("strb_upper_ignored", rd, 32'h0);
        axi_write(32'h4, 32'hFFFF_FF5A, 4'b0001, 0, resp);
        axi_read(32'h4, rd, resp);
        check("strb_byte0", rd, 32'h5A);

        // ID write ignored
        axi_write(32'h1C, 32'h0, 4'hF, 0, resp);
        check("id_write_bresp", 32'(resp), 32'd0);
        axi_read(32'h1C, rd, resp);
        check("id_read", rd, ID);
        pulse_sof();
        check("px_int_after_sof", 32'(px_int), 32'h5A);

        // Write completion coinciding with sof, then B held off for 5 cycles
        axi_write(32'h0, 32'h11, 4'hF, 0, resp);
        write_start(32'h0, 32'h22, 4'hF, 0, 1'b1);
`ifdef PX_SKIP_CSR_SHADOW_EN
        check("sof_coincide_active", 32'(px_skip), 32'h11);
`else
        check("sof_coincide_direct", 32'(px_skip), 32'h22);
`endif
        write_finish(5, resp);
        axi_read(32'h18, rd, resp);
`ifdef PX_SKIP_CSR_SHADOW_EN
        check("sof_coincide_pending", rd, 32'h5);
`else
        check("sof_coincide_ctrl", rd, 32'h1);
`endif
        pulse_sof();
        check("sof_coincide_next", 32'(px_skip), 32'h22);
        axi_read(32'h18, rd, resp);
        check("sof_coincide_cleared", rd, 32'h1);

        // PX_INTERVAL visibility at the bvalid cycle
        write_start(32'h4, 32'h10, 4'hF, 0, 1'b0);
`ifdef PX_SKIP_CSR_SHADOW_EN
        check("px_int_held", 32'(px_int), 32'h5A);
`else
        check("px_int_at_bvalid", 32'(px_int), 32'h10);
`endif
        write_finish(0, resp);

        // Reset with AW captured but W outstanding
        bus.awaddr  = 32'h8;
        bus.awvalid = 1'b1;
        cycle();
        bus.awvalid = 1'b0;
        check("aw_captured", 32'({bus.awready, bus.wready}), 32'b01);
        rst_n = 1'b0;
        #3;
        check("midrst_ready", 32'({bus.awready, bus.wready, bus.bvalid}), 32'b110);
        check("midrst_outputs", 32'({px_skip, px_int, ln_int, 7'd0, skip_en}), 32'd0);
        rst_n = 1'b1;
        cycle();
        bus.wdata  = 32'h99;
        bus.wstrb  = 4'hF;
        bus.wvalid = 1'b1;
        cycle();
        bus.wvalid = 1'b0;
        check("midrst_no_write", 32'(bus.bvalid), 32'd0);
        axi_read(32'h8, rd, resp);
        check("midrst_reg", rd, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
